// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    BRANCH = 2'd0,
    JUMP   = 2'd1,
    CALL   = 2'd2,
    RET    = 2'd3
  } redir_t;

  localparam int PC_SEQ_MAX_RAS_DEPTH = 16;

  // Only the low byte of an address matters, because INSTR_BYTES is at most 8.
  function automatic logic is_aligned(input logic [7:0] addr_lo, input int instr_bytes);
    logic [7:0] mask;
    mask = 8'(instr_bytes - 1);
    return (addr_lo & mask) == 8'h00;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_m1;
  logic [PW:0]     count;

  assign ptr_m1 = ptr - PW'(1);
  assign top    = mem[ptr_m1];
  assign empty  = (count == '0);
  assign full   = (count == (PW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (!full) count <= count + (PW+1)'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr_m1;
      count <= count - (PW+1)'(1);
    end
  end

  // Entries are not reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: priority mux, PC register and error pulses.
// Return-address stack built only when PC_SEQ_RAS_EN is defined.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0040_0000,
  parameter int               INSTR_BYTES  = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            pc_load_valid,
  input  logic [XLEN-1:0] pc_load_value,
  input  logic            redirect_valid,
  input  logic [1:0]      redirect_kind,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_valid,
  output logic            misalign_err,
  output logic            ras_underflow,
  output logic            ras_empty,
  output logic            ras_full
);

  if (INSTR_BYTES < 1 || INSTR_BYTES > 8 || (INSTR_BYTES & (INSTR_BYTES - 1)) != 0 ||
      RAS_DEPTH < 2 || RAS_DEPTH > PC_SEQ_MAX_RAS_DEPTH ||
      (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_param
    $error("pc_sequencer: INSTR_BYTES or RAS_DEPTH out of range");
  end

  redir_t          kind;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] redir_dest;
  logic            ret_hit;
  logic            push_c;
  logic            pop_c;
  logic            misalign_c;
  logic            underflow_c;

  assign kind   = redir_t'(redirect_kind);
  assign pc_inc = pc + XLEN'(INSTR_BYTES);

`ifdef PC_SEQ_RAS_EN
  logic [XLEN-1:0] ras_top;

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .pop       (pop_c),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign ret_hit    = (kind == RET) && !ras_empty;
  assign redir_dest = ret_hit ? ras_top : redirect_target;
`else
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
  assign ret_hit    = 1'b0;
  assign redir_dest = redirect_target;
`endif

  always_comb begin
    pc_next     = stall ? pc : pc_inc;
    push_c      = 1'b0;
    pop_c       = 1'b0;
    misalign_c  = 1'b0;
    underflow_c = 1'b0;
    if (reset) begin
      pc_next = RESET_VECTOR;
    end else if (pc_load_valid) begin
      // A dropped load also suppresses any redirect in the same cycle.
      if (is_aligned(pc_load_value[7:0], INSTR_BYTES)) pc_next = pc_load_value;
      else                                             misalign_c = 1'b1;
    end else if (redirect_valid) begin
      if (is_aligned(redir_dest[7:0], INSTR_BYTES)) begin
        pc_next = redir_dest;
`ifdef PC_SEQ_RAS_EN
        push_c      = (kind == CALL);
        pop_c       = ret_hit;
        underflow_c = (kind == RET) && !ret_hit;
`endif
      end else begin
        misalign_c = 1'b1;
      end
    end
  end

  // Stage boundary: PC register, valid and one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_VECTOR;
      pc_valid      <= 1'b0;
      misalign_err  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc            <= pc_next;
      pc_valid      <= 1'b1;
      misalign_err  <= misalign_c;
      ras_underflow <= underflow_c;
    end
  end

endmodule
